// File: rtl/uart_rx_pkt_ctrl.sv
// Frame controller behind uart_rx: SYNC, ADDR, DATA, CHK byte frames become one-cycle register writes.
// Optional inter-byte timeout is enabled by defining UART_PKT_TIMEOUT_EN.
//
// state | meaning
// HUNT  | idle, dropping bytes until SYNC_BYTE arrives
// ADDR  | waiting for the address byte
// DATA  | waiting for the data byte
// CHK   | waiting for the checksum byte (SYNC ^ addr ^ data)
module uart_rx_pkt_ctrl #(
  parameter int          SYS_CLOCK    = 50000000,
  parameter int          BYTE_TIMEOUT = 50000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       i_SysClock,
  input  logic       i_ResetN,
  input  logic       i_RxDone,
  input  logic [7:0] i_RxByte,
  output logic       o_WrEn,
  output logic [7:0] o_WrAddr,
  output logic [7:0] o_WrData,
  output logic       o_PktErr,
  output logic       o_Timeout,
  output logic [7:0] o_PktCnt,
  output logic       o_Busy
);

  typedef enum logic [1:0] {HUNT = 2'd0, ADDR = 2'd1, DATA = 2'd2, CHK = 2'd3} state_t;

  state_t     state_q, state_d;
  logic       rxdone_q;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       wr_en_q, wr_en_d;
  logic       pkt_err_q, pkt_err_d;
  logic       timeout_q, timeout_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] pkt_cnt_q, pkt_cnt_d;
  logic       byte_stb;
  logic       chk_ok;
  logic       tmo_hit;

  // rxdone_q resets high so a receiver that is idle out of reset produces no strobe
  assign byte_stb = i_RxDone & ~rxdone_q;
  assign chk_ok   = (i_RxByte == (SYNC_BYTE ^ addr_q ^ data_q));

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = $clog2(BYTE_TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // A strobe in the terminal cycle wins over the timeout
  assign tmo_hit = (state_q != HUNT) && !byte_stb && (tmo_cnt_q == TW'(BYTE_TIMEOUT));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + TW'(1);
    if (byte_stb || (state_q == HUNT) || tmo_hit) tmo_cnt_d = '0;
  end

  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) tmo_cnt_q <= '0;
    else           tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      state_q   <= HUNT;
      rxdone_q  <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      pkt_err_q <= 1'b0;
      timeout_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rxdone_q  <= i_RxDone;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      pkt_err_q <= pkt_err_d;
      timeout_q <= timeout_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (byte_stb && (i_RxByte == SYNC_BYTE)) state_d = ADDR;
      ADDR:    if (byte_stb) state_d = DATA;
      DATA:    if (byte_stb) state_d = CHK;
      CHK:     if (byte_stb) state_d = HUNT;
      default: state_d = HUNT;
    endcase
    if (tmo_hit) state_d = HUNT;
  end

  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    wr_en_d   = 1'b0;
    pkt_err_d = 1'b0;
    timeout_d = tmo_hit;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pkt_cnt_d = pkt_cnt_q;
    if (byte_stb) begin
      case (state_q)
        ADDR: addr_d = i_RxByte;
        DATA: data_d = i_RxByte;
        CHK: begin
          if (chk_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
            pkt_cnt_d = pkt_cnt_q + 8'd1;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_WrEn    = wr_en_q;
  assign o_WrAddr  = wr_addr_q;
  assign o_WrData  = wr_data_q;
  assign o_PktErr  = pkt_err_q;
  assign o_Timeout = timeout_q;
  assign o_PktCnt  = pkt_cnt_q;
  assign o_Busy    = (state_q != HUNT);

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: good/bad frames, hunt filtering, timeout, reset mid-frame, count wrap.
module tb_uart_rx_pkt_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_byte;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       pkt_err;
  logic       tmo;
  logic [7:0] pkt_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;
  int n_err  = 0;
  int n_tmo  = 0;
  int base_wr;
  int base_err;
  int base_tmo;

  uart_rx_pkt_ctrl #(
    .SYS_CLOCK   (50000000),
    .BYTE_TIMEOUT(100),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .i_SysClock(clk),
    .i_ResetN  (rst_n),
    .i_RxDone  (rx_done),
    .i_RxByte  (rx_byte),
    .o_WrEn    (wr_en),
    .o_WrAddr  (wr_addr),
    .o_WrData  (wr_data),
    .o_PktErr  (pkt_err),
    .o_Timeout (tmo),
    .o_PktCnt  (pkt_cnt),
    .o_Busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en)   n_wr++;
    if (pkt_err) n_err++;
    if (tmo)     n_tmo++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    rx_byte = b;
    rx_done = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  task automatic mark();
    base_wr  = n_wr;
    base_err = n_err;
    base_tmo = n_tmo;
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_done = 1'b1;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_wren", {31'd0, wr_en}, 32'd0);
    check_val("rst_addr", {24'd0, wr_addr}, 32'd0);
    check_val("rst_data", {24'd0, wr_data}, 32'd0);
    check_val("rst_cnt",  {24'd0, pkt_cnt}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_err",  {31'd0, pkt_err}, 32'd0);
    check_val("rst_tmo",  {31'd0, tmo}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("idle_nostb", {24'd0, pkt_cnt}, 32'd0);

    // good frame
    mark();
    send_byte(8'hA5);
    check_val("busy_after_sync", {31'd0, busy}, 32'd1);
    send_byte(8'h10);
    send_byte(8'h3C);
    send_byte(8'h89);
    check_val("good_wr",   n_wr - base_wr, 32'd1);
    check_val("good_err",  n_err - base_err, 32'd0);
    check_val("good_addr", {24'd0, wr_addr}, 32'h10);
    check_val("good_data", {24'd0, wr_data}, 32'h3C);
    check_val("good_cnt",  {24'd0, pkt_cnt}, 32'd1);
    check_val("good_busy", {31'd0, busy}, 32'd0);

    // bad checksum
    mark();
    send_frame(8'h20, 8'h77, 8'h88);
    check_val("bad_err",  n_err - base_err, 32'd1);
    check_val("bad_wr",   n_wr - base_wr, 32'd0);
    check_val("bad_addr", {24'd0, wr_addr}, 32'h10);
    check_val("bad_data", {24'd0, wr_data}, 32'h3C);
    check_val("bad_cnt",  {24'd0, pkt_cnt}, 32'd1);
    check_val("bad_busy", {31'd0, busy}, 32'd0);

    // hunt filtering
    mark();
    send_byte(8'h00);
    send_byte(8'hFF);
    check_val("hunt_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h01, 8'h02, 8'hA6);
    check_val("hunt_wr",   n_wr - base_wr, 32'd1);
    check_val("hunt_addr", {24'd0, wr_addr}, 32'h01);
    check_val("hunt_data", {24'd0, wr_data}, 32'h02);
    check_val("hunt_cnt",  {24'd0, pkt_cnt}, 32'd2);

    // sync byte mid-frame is plain data: A5 ^ A5 ^ 33 = 33
    mark();
    send_frame(8'hA5, 8'h33, 8'h33);
    check_val("midsync_wr",   n_wr - base_wr, 32'd1);
    check_val("midsync_addr", {24'd0, wr_addr}, 32'hA5);
    check_val("midsync_cnt",  {24'd0, pkt_cnt}, 32'd3);

    // inter-byte silence
    mark();
    send_byte(8'hA5);
    repeat (80) @(negedge clk);
    send_byte(8'h10);
`ifdef UART_PKT_TIMEOUT_EN
    check_val("near_tmo_none", n_tmo - base_tmo, 32'd0);
    check_val("near_tmo_busy", {31'd0, busy}, 32'd1);
    repeat (110) @(negedge clk);
    check_val("tmo_pulse", n_tmo - base_tmo, 32'd1);
    check_val("tmo_busy",  {31'd0, busy}, 32'd0);
    send_frame(8'h10, 8'h3C, 8'h89);
`else
    repeat (200) @(negedge clk);
    check_val("notmo_pulse", n_tmo - base_tmo, 32'd0);
    check_val("notmo_busy",  {31'd0, busy}, 32'd1);
    send_byte(8'h3C);
    send_byte(8'h89);
`endif
    check_val("after_silence_wr",  n_wr - base_wr, 32'd1);
    check_val("after_silence_cnt", {24'd0, pkt_cnt}, 32'd4);

    // reset mid-frame
    mark();
    send_byte(8'hA5);
    send_byte(8'h10);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_cnt",  {24'd0, pkt_cnt}, 32'd0);
    check_val("midrst_addr", {24'd0, wr_addr}, 32'd0);
    check_val("midrst_data", {24'd0, wr_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h10, 8'h3C, 8'h89);
    check_val("midrst_wr",    n_wr - base_wr, 32'd1);
    check_val("midrst_perr",  n_err - base_err, 32'd0);
    check_val("postrst_cnt",  {24'd0, pkt_cnt}, 32'd1);
    check_val("postrst_addr", {24'd0, wr_addr}, 32'h10);

    // 256 good frames wrap the counter
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mark();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      logic [7:0] d;
      a = i[7:0];
      d = a * 8'd3;
      send_frame(a, d, 8'hA5 ^ a ^ d);
      if (i == 127) check_val("wrap_mid_cnt", {24'd0, pkt_cnt}, 32'd128);
    end
    check_val("wrap_cnt",  {24'd0, pkt_cnt}, 32'd0);
    check_val("wrap_wr",   n_wr - base_wr, 32'd256);
    check_val("wrap_err",  n_err - base_err, 32'd0);
    check_val("wrap_addr", {24'd0, wr_addr}, 32'hFF);
    check_val("wrap_data", {24'd0, wr_data}, 32'hFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
# uart_rx_pkt_ctrl

Frame controller that sits directly behind `uart_rx` and turns its raw byte stream into register-write commands. It watches `uart_rx`'s done level for byte completion, hunts for a sync byte, and collects address, data and checksum. On a good frame it issues a one-cycle register write. Bad frames and stalled frames are discarded and flagged.

## Interface
Parameters:
- `SYS_CLOCK`, default 50000000: system clock in Hz. Documentation only; unused in logic.
- `BYTE_TIMEOUT`, default 50000: maximum clock cycles allowed between consecutive bytes of one frame.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `i_SysClock`, input, 1: system clock. All logic is on the rising edge.
- `i_ResetN`, input, 1: asynchronous, active-low reset.
- `i_RxDone`, input, 1: done level from `uart_rx`. High while the receiver is idle or in its stop bit.
- `i_RxByte`, input, 8: received byte from `uart_rx`. Stable while `i_RxDone` is high.
- `o_WrEn`, output, 1: one-cycle write strobe.
- `o_WrAddr`, output, 8: write address. Held until the next good frame.
- `o_WrData`, output, 8: write data. Held until the next good frame.
- `o_PktErr`, output, 1: one-cycle pulse on a checksum mismatch.
- `o_Timeout`, output, 1: one-cycle pulse when a frame is abandoned for inter-byte timeout.
- `o_PktCnt`, output, 8: count of good frames. Wraps from 255 to 0.
- `o_Busy`, output, 1: high whenever the state is not HUNT.

## Operation
- **Byte strobe.** `byte_stb = i_RxDone & ~rxdone_q`.
  - `rxdone_q` is a registered copy of `i_RxDone` and resets to 1, so no strobe fires out of reset.
  - `i_RxByte` is sampled in the strobe cycle.
- **FSM states:** HUNT, ADDR, DATA, CHK.
  - HUNT: on strobe with byte == `SYNC_BYTE`, go to ADDR. Any other byte is dropped.
  - ADDR: on strobe, latch `addr_r`, go to DATA.
  - DATA: on strobe, latch `data_r`, go to CHK.
  - CHK: on strobe, compare the byte with `SYNC_BYTE ^ addr_r ^ data_r` (8-bit XOR).
    - Match: load `o_WrAddr`/`o_WrData`, pulse `o_WrEn`, increment `o_PktCnt`.
    - Mismatch: pulse `o_PktErr`. `o_WrAddr`/`o_WrData` are unchanged.
    - Either way, go to HUNT.
- A sync byte received in ADDR/DATA/CHK is treated as ordinary data. There is no resync mid-frame.
- **Reset values:** every output is 0; the state is HUNT; `addr_r`, `data_r` and the timeout counter are 0.
- **Reset mid-frame:** asynchronous return to HUNT. The partial frame is lost and no pulse is issued.
- Invalid state encoding goes to HUNT.

## Timing
- Strobe detection: 1 cycle after the `i_RxDone` rising edge at the block boundary.
  - Strobe in cycle N means the FSM has updated at the edge ending N.
- `o_WrEn`, `o_PktErr`, `o_Timeout`: registered, high for exactly cycle N+1 after the deciding strobe or timeout cycle N.
  - `o_WrAddr`, `o_WrData` and `o_PktCnt` are updated in the same edge as `o_WrEn`.
- Back-to-back frames are accepted. A SYNC strobe arriving while `o_WrEn` is high is processed normally.
- **Timeout counter** (width `$clog2(BYTE_TIMEOUT+1)`):
  - Cleared on every strobe and while in HUNT; otherwise increments by 1 per cycle.
  - When it equals `BYTE_TIMEOUT` with no strobe in that cycle: go to HUNT, pulse `o_Timeout`, clear the counter.
  - If a strobe and counter == `BYTE_TIMEOUT` coincide, the strobe wins: the byte is processed and no timeout occurs.
- `o_PktCnt` wrap: 8'hFF + 1 = 8'h00. No flag.

## Configuration
- Macro `UART_PKT_TIMEOUT_EN`.
- **Defined:** the timeout counter and `o_Timeout` behave as above.
- **Undefined:**
  - No counter is synthesized.
  - `o_Timeout` is tied to 0.
  - A partial frame waits indefinitely for its next byte.
  - `BYTE_TIMEOUT` is ignored.

## Test plan
- Good frame: bytes A5, 10, 3C, 89 → one `o_WrEn` pulse, `o_WrAddr`=8'h10, `o_WrData`=8'h3C, `o_PktCnt`=1, no `o_PktErr`.
- Bad checksum: A5, 10, 3C, 88 → `o_PktErr` pulse, no `o_WrEn`, outputs unchanged, FSM back in HUNT.
- Hunt filtering: 00, FF, A5, 01, 02, A6 → only the A5-led frame is accepted, with `o_WrAddr`=8'h01 and `o_WrData`=8'h02.
- Timeout (macro defined, `BYTE_TIMEOUT`=100): A5, 10, then silence for 101 cycles → `o_Timeout` pulse, `o_Busy`=0. A following good frame is still accepted.
- Reset mid-frame: A5, 10, then assert `i_ResetN`=0 → all outputs 0, `o_Busy`=0. After release, a good frame is accepted with `o_PktCnt`=1.
- Counter wrap: 256 good frames → `o_PktCnt` returns to 0 and `o_WrEn` fires 256 times.
